// File: rtl/dec_sel_sequencer_if.sv
// dec_sel_sequencer_if: request handshake, hold and decoder-drive bundle of the select sequencer
// Signals:
//   In_Valid/In_Sel/In_Ready : upstream request handshake (2-bit select index)
//   Hold                     : downstream stall that freezes the issued select
//   Upper/Lower/Enable       : registered decoder inputs
//   Count                    : queued entries (0..4), excluding the issued one
interface dec_sel_sequencer_if;
    logic       In_Valid;
    logic [1:0] In_Sel;
    logic       In_Ready;
    logic       Hold;
    logic       Upper;
    logic       Lower;
    logic       Enable;
    logic [2:0] Count;

    modport master (
        output In_Valid, In_Sel, Hold,
        input  In_Ready, Upper, Lower, Enable, Count
    );

    modport slave (
        input  In_Valid, In_Sel, Hold,
        output In_Ready, Upper, Lower, Enable, Count
    );
endinterface

// File: rtl/dec_sel_sequencer.sv
// dec_sel_sequencer: 4-deep FIFO of 2-bit selects issued in order onto registered decoder lines
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : dec_sel_sequencer_if.slave (In_Valid/In_Sel/In_Ready, Hold, Upper/Lower/Enable, Count)
module dec_sel_sequencer #(
    parameter int UUID = 0,
    parameter     NAME = ""
) (
    input logic                 clk,
    input logic                 rst,
    dec_sel_sequencer_if.slave  bus
);
    logic [1:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] cnt;
    logic       upper;
    logic       lower;
    logic       enable;
    logic       push;
    logic       pop;
    logic [1:0] head;

    // Ready looks only at occupancy, so a full FIFO refuses even while it pops.
    assign bus.In_Ready = (cnt != 3'd4);
    assign push         = bus.In_Valid && bus.In_Ready;
    assign pop          = !bus.Hold && (cnt != 3'd0);
    assign head         = mem[rd_ptr];

    assign bus.Upper  = upper;
    assign bus.Lower  = lower;
    assign bus.Enable = enable;
    assign bus.Count  = cnt;

    // Storage carries no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.In_Sel;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            cnt    <= 3'd0;
            upper  <= 1'b0;
            lower  <= 1'b0;
            enable <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            cnt <= cnt + 3'(push) - 3'(pop);
            // An empty FIFO loads zeros so the decoder never sees a stale index while disabled.
            if (!bus.Hold) begin
                upper  <= pop && head[1];
                lower  <= pop && head[0];
                enable <= pop;
            end
        end
    end
endmodule
